// File: rtl/img_fetch_unit_pkg.sv
// rtl/img_fetch_unit_pkg.sv - shared opcodes, fetch FSM states and stride encodings
package img_fetch_unit_pkg;

   // Decoder opcodes and operand selects used across the accelerator
   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_CONV    = 3'd1,
      OP_RELU    = 3'd2,
      OP_MAXPOOL = 3'd3,
      OP_LOAD    = 3'd4
   } opcode_e;

   localparam logic [1:0] OP_SEL_IMG = 2'd0;
   localparam logic [1:0] OP_SEL_KER = 2'd1;
   localparam logic [1:0] OP_SEL_OUT = 2'd2;

   // Fetch FSM states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // stride2 input encoding
   localparam logic STRIDE_1 = 1'b0;
   localparam logic STRIDE_2 = 1'b1;

endpackage

// File: rtl/img_fetch_unit_win_fifo.sv
// rtl/img_fetch_unit_win_fifo.sv - 2-entry fall-through FIFO with registered head
module win_fifo #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic [1:0]       count_q;
   logic             pop_ok;

   // a pop against an empty FIFO is meaningless, so it is ignored
   assign pop_ok = pop && (count_q != 2'd0);

   // head_q always holds the oldest entry so the output is straight from a flop
   always_ff @(posedge clk) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         case ({push, pop_ok})
            2'b10: begin
               if (count_q == 2'd0) head_q <= din;
               else                 tail_q <= din;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_q <= din;
               end else begin
                  head_q <= tail_q;
                  tail_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = head_q;
   assign valid = (count_q != 2'd0);
   assign count = count_q;

endmodule

// File: rtl/img_fetch_unit.sv
// rtl/img_fetch_unit.sv - sliding-window address generator and pixel streamer
module img_fetch_unit
   import img_fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH        = 10,
   parameter int IMG_SIZE_WIDTH    = 5,
   parameter int KERNEL_SIZE_WIDTH = 3,
   parameter int DATA_WIDTH        = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         start,
   input  logic                         img_fetch_en,
   input  logic [ADDR_WIDTH-1:0]        img_addr,
   input  logic [IMG_SIZE_WIDTH-1:0]    img_size,
   input  logic [KERNEL_SIZE_WIDTH-1:0] ker_size,
   input  logic                         stride2,
   output logic                         bram_img_en,
   output logic [ADDR_WIDTH-1:0]        bram_img_addr,
   input  logic [DATA_WIDTH-1:0]        bram_img_dout,
   output logic [DATA_WIDTH-1:0]        win_data,
   output logic                         win_valid,
   input  logic                         win_ready,
   output logic                         win_last,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   // position arithmetic width: holds pos + stride + Keff without overflow
   localparam int PW = IMG_SIZE_WIDTH + KERNEL_SIZE_WIDTH + 1;

   logic [1:0]                   state;
   logic [IMG_SIZE_WIDTH-1:0]    n_q;
   logic [KERNEL_SIZE_WIDTH-1:0] keff_q;
   logic                         s2_q;
   logic [IMG_SIZE_WIDTH-1:0]    orow_pos;
   logic [IMG_SIZE_WIDTH-1:0]    ocol_pos;
   logic [KERNEL_SIZE_WIDTH-1:0] kr;
   logic [KERNEL_SIZE_WIDTH-1:0] kc;
   logic [ADDR_WIDTH-1:0]        wrow_base;
   logic [ADDR_WIDTH-1:0]        win_base;
   logic [ADDR_WIDTH-1:0]        erow_base;
   logic                         rd_pend;
   logic                         last_pend;
   logic [1:0]                   fifo_count;

   logic [KERNEL_SIZE_WIDTH-1:0] keff_in;
   logic                         start_go;
   logic                         k_gt_n;
   logic [PW-1:0]                stride_pw;
   logic [IMG_SIZE_WIDTH-1:0]    stride_pos;
   logic                         col_more;
   logic                         row_more;
   logic                         kc_end;
   logic                         kr_end;
   logic                         last_elem;
   logic [2:0]                   credits;
   logic                         pop;
   logic                         issue;
   logic [ADDR_WIDTH-1:0]        n_ext;
   logic [ADDR_WIDTH-1:0]        row_step;
   logic [ADDR_WIDTH-1:0]        col_step;

   assign keff_in  = (ker_size == '0) ? KERNEL_SIZE_WIDTH'(1) : ker_size;
   assign start_go = start && img_fetch_en && (state == ST_IDLE);
   assign k_gt_n   = PW'(keff_in) > PW'(img_size);

   // a further window exists when the next origin plus Keff still fits in N
   assign stride_pw  = (s2_q == STRIDE_2) ? PW'(2) : PW'(1);
   assign stride_pos = (s2_q == STRIDE_2) ? IMG_SIZE_WIDTH'(2) : IMG_SIZE_WIDTH'(1);
   assign col_more   = (PW'(ocol_pos) + stride_pw + PW'(keff_q)) <= PW'(n_q);
   assign row_more   = (PW'(orow_pos) + stride_pw + PW'(keff_q)) <= PW'(n_q);
   assign kc_end     = (kc == keff_q - KERNEL_SIZE_WIDTH'(1));
   assign kr_end     = (kr == keff_q - KERNEL_SIZE_WIDTH'(1));
   assign last_elem  = kc_end && kr_end && !col_more && !row_more;

   // stepping by S rows is N or 2N, done with a shift rather than a multiply
   assign n_ext    = ADDR_WIDTH'(n_q);
   assign row_step = (s2_q == STRIDE_2) ? (n_ext << 1) : n_ext;
   assign col_step = (s2_q == STRIDE_2) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);

   // credits count every read that will still need a FIFO slot
   assign credits = 3'(fifo_count) + 3'(rd_pend);
   assign pop     = win_valid && win_ready;
   assign issue   = (state == ST_FETCH) && ((credits - 3'(pop)) < 3'd2);

   assign bram_img_en = issue;
   assign busy        = (state == ST_FETCH) || (state == ST_DRAIN);
   assign done        = (state == ST_DONE);

   // FSM, job capture and incremental window walk over the image
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= ST_IDLE;
         n_q           <= '0;
         keff_q        <= '0;
         s2_q          <= 1'b0;
         orow_pos      <= '0;
         ocol_pos      <= '0;
         kr            <= '0;
         kc            <= '0;
         wrow_base     <= '0;
         win_base      <= '0;
         erow_base     <= '0;
         bram_img_addr <= '0;
         err           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_go) begin
                  n_q           <= img_size;
                  keff_q        <= keff_in;
                  s2_q          <= stride2;
                  orow_pos      <= '0;
                  ocol_pos      <= '0;
                  kr            <= '0;
                  kc            <= '0;
                  wrow_base     <= img_addr;
                  win_base      <= img_addr;
                  erow_base     <= img_addr;
                  bram_img_addr <= img_addr;
                  err           <= k_gt_n;
                  state         <= k_gt_n ? ST_DONE : ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (issue) begin
                  if (last_elem) state <= ST_DRAIN;
                  if (!kc_end) begin
                     kc            <= kc + KERNEL_SIZE_WIDTH'(1);
                     bram_img_addr <= bram_img_addr + ADDR_WIDTH'(1);
                  end else if (!kr_end) begin
                     kc            <= '0;
                     kr            <= kr + KERNEL_SIZE_WIDTH'(1);
                     erow_base     <= erow_base + n_ext;
                     bram_img_addr <= erow_base + n_ext;
                  end else if (col_more) begin
                     kc            <= '0;
                     kr            <= '0;
                     ocol_pos      <= ocol_pos + stride_pos;
                     win_base      <= win_base + col_step;
                     erow_base     <= win_base + col_step;
                     bram_img_addr <= win_base + col_step;
                  end else if (row_more) begin
                     kc            <= '0;
                     kr            <= '0;
                     ocol_pos      <= '0;
                     orow_pos      <= orow_pos + stride_pos;
                     wrow_base     <= wrow_base + row_step;
                     win_base      <= wrow_base + row_step;
                     erow_base     <= wrow_base + row_step;
                     bram_img_addr <= wrow_base + row_step;
                  end
               end
            end
            ST_DRAIN: begin
               // leave as the final element is accepted so done follows it directly
               if (!rd_pend && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
                  state <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // one read in flight at most; remember whether it closes a window
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_pend   <= 1'b0;
         last_pend <= 1'b0;
      end else begin
         rd_pend   <= issue;
         last_pend <= kc_end && kr_end;
      end
   end

   win_fifo #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_win_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (rd_pend),
      .din   ({last_pend, bram_img_dout}),
      .pop   (pop),
      .dout  ({win_last, win_data}),
      .valid (win_valid),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_img_fetch_unit.sv
// tb/tb_img_fetch_unit.sv - scoreboard bench for img_fetch_unit
module tb_img_fetch_unit;

   logic       clk;
   logic       rstn;
   logic       start;
   logic       img_fetch_en;
   logic [9:0] img_addr;
   logic [4:0] img_size;
   logic [2:0] ker_size;
   logic       stride2;
   logic       bram_img_en;
   logic [9:0] bram_img_addr;
   logic [7:0] bram_img_dout;
   logic [7:0] win_data;
   logic       win_valid;
   logic       win_ready;
   logic       win_last;
   logic       busy;
   logic       done;
   logic       err;

   img_fetch_unit dut (
      .clk           (clk),
      .rstn          (rstn),
      .start         (start),
      .img_fetch_en  (img_fetch_en),
      .img_addr      (img_addr),
      .img_size      (img_size),
      .ker_size      (ker_size),
      .stride2       (stride2),
      .bram_img_en   (bram_img_en),
      .bram_img_addr (bram_img_addr),
      .bram_img_dout (bram_img_dout),
      .win_data      (win_data),
      .win_valid     (win_valid),
      .win_ready     (win_ready),
      .win_last      (win_last),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   logic [7:0] mem [1024];
   logic [9:0] exp_addr [$];
   logic [8:0] exp_data [$];
   int         n_checks;
   int         n_fail;
   int         issued;
   int         popped;
   int         xfer_count;
   time        last_xfer_t;
   bit         rand_ready;
   bit         mon_en;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // image BRAM: one-cycle read latency
   initial bram_img_dout = 8'h00;
   always @(posedge clk) if (bram_img_en) bram_img_dout <= mem[bram_img_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ready driver: always ready, or a 50% coin flip per cycle
   initial begin
      win_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         win_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
      end
   end

   // monitor: pops the scoreboards on every read and every transfer
   initial begin
      logic [9:0] a;
      logic [8:0] d;
      bit         xfer;
      forever begin
         @(negedge clk);
         if (rstn && mon_en) begin
            xfer = win_valid && win_ready;
            if (bram_img_en) begin
               if (!xfer) check("credit_limit", 32'((issued - popped) < 2), 32'd1);
               if (exp_addr.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_read: addr %0h with no read expected at %0t", bram_img_addr, $time);
               end else begin
                  a = exp_addr.pop_front();
                  check("bram_addr", 32'(bram_img_addr), 32'(a));
               end
               issued++;
            end
            if (xfer) begin
               if (exp_data.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_xfer: data %0h with none expected at %0t", win_data, $time);
               end else begin
                  d = exp_data.pop_front();
                  check("win_data", 32'(win_data), 32'(d[7:0]));
                  check("win_last", 32'(win_last), 32'(d[8]));
               end
               popped++;
               xfer_count++;
               last_xfer_t = $time;
            end
         end
      end
   end

   // reference: plain nested loops over windows and kernel elements
   task automatic build_model(input logic [9:0] base, input int n, input int k, input bit s2,
                              output int total, output bit e);
      int keff, s, m, off;
      logic [9:0] a;
      keff  = (k == 0) ? 1 : k;
      s     = s2 ? 2 : 1;
      total = 0;
      e     = (keff > n);
      if (!e) begin
         m = (n - keff) / s + 1;
         for (int orow = 0; orow < m; orow++)
            for (int ocol = 0; ocol < m; ocol++)
               for (int kr = 0; kr < keff; kr++)
                  for (int kc = 0; kc < keff; kc++) begin
                     off = (orow * s + kr) * n + ocol * s + kc;
                     a   = base + 10'(off);
                     exp_addr.push_back(a);
                     exp_data.push_back({(kr == keff - 1) && (kc == keff - 1), mem[a]});
                     total++;
                  end
      end
   endtask

   task automatic launch(input logic [9:0] base, input int n, input int k, input bit s2,
                         output int total, output bit e);
      build_model(base, n, k, s2, total, e);
      xfer_count = 0;
      @(posedge clk); #1;
      start = 1'b1; img_fetch_en = 1'b1; img_addr = base;
      img_size = 5'(n); ker_size = 3'(k); stride2 = s2;
      @(posedge clk); #1;
      start = 1'b0;
      img_addr = 10'($urandom); img_size = 5'($urandom); ker_size = 3'($urandom);
      stride2 = 1'($urandom); img_fetch_en = 1'($urandom);
   endtask

   task automatic run_job(input logic [9:0] base, input int n, input int k, input bit s2, input bit rnd);
      int total;
      bit e;
      bit done_seen;
      rand_ready = rnd;
      launch(base, n, k, s2, total, e);
      @(negedge clk);
      check("busy_c1", 32'(busy), 32'(!e));
      check("done_c1", 32'(done), 32'(e));
      check("err_c1", 32'(err), 32'(e));
      if (!e) begin
         @(negedge clk);
         check("valid_c2", 32'(win_valid), 32'd0);
         @(negedge clk);
         check("valid_c3", 32'(win_valid), 32'd1);
         if (total >= 4) begin
            @(posedge clk); #1;
            start = 1'b1; img_fetch_en = 1'b1; img_addr = 10'($urandom);
            img_size = 5'd1; ker_size = 3'd1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         done_seen = 1'b0;
         for (int i = 0; i < 8000 && !done_seen; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
         end
         check("done_seen", 32'(done_seen), 32'd1);
         if (done_seen) begin
            check("done_gap", 32'($time - last_xfer_t), 32'd10);
            check("busy_at_done", 32'(busy), 32'd0);
         end
      end
      check("xfer_count", 32'(xfer_count), 32'(total));
      check("addr_left", 32'(exp_addr.size()), 32'd0);
      check("data_left", 32'(exp_data.size()), 32'd0);
      check("err_final", 32'(err), 32'(e));
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      rand_ready = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_bram_en", 32'(bram_img_en), 32'd0);
      check("rst_bram_addr", 32'(bram_img_addr), 32'd0);
      check("rst_win_data", 32'(win_data), 32'd0);
      check("rst_win_valid", 32'(win_valid), 32'd0);
      check("rst_win_last", 32'(win_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
   endtask

   initial begin
      int  total;
      bit  e;
      n_checks = 0; n_fail = 0; issued = 0; popped = 0; xfer_count = 0;
      last_xfer_t = 0; rand_ready = 1'b0; mon_en = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      rstn = 1'b0; start = 1'b0; img_fetch_en = 1'b0; img_addr = '0;
      img_size = '0; ker_size = '0; stride2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
      rstn = 1'b1; mon_en = 1'b1;

      run_job(10'h010, 3, 2, 1'b0, 1'b0);
      run_job(10'h000, 4, 2, 1'b1, 1'b0);
      run_job(10'h020, 3, 0, 1'b0, 1'b0);
      run_job(10'h010, 3, 2, 1'b0, 1'b1);
      run_job(10'h055, 7, 3, 1'b0, 1'b1);
      run_job(10'h100, 3, 5, 1'b0, 1'b0);
      run_job(10'h3FE, 2, 1, 1'b0, 1'b0);
      run_job(10'h040, 0, 0, 1'b0, 1'b0);

      // start without img_fetch_en must not launch anything
      @(posedge clk); #1;
      start = 1'b1; img_fetch_en = 1'b0; img_size = 5'd3; ker_size = 3'd1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("no_en_busy", 32'(busy), 32'd0);
      check("no_en_done", 32'(done), 32'd0);

      // reset in the middle of a job
      rand_ready = 1'b1;
      launch(10'h080, 6, 3, 1'b0, total, e);
      repeat (9) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs();
      exp_addr.delete();
      exp_data.delete();
      issued = 0;
      popped = 0;
      rand_ready = 1'b0;
      rstn = 1'b1;

      run_job(10'h0C3, 5, 3, 1'b0, 1'b1);
      for (int j = 0; j < 4; j++)
         run_job(10'($urandom), $urandom_range(1, 9), $urandom_range(0, 4), 1'($urandom), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/img_fetch_unit.md
# img_fetch_unit

Address generator and window streamer between the instruction decoder and the PE array. On a start pulse it captures the image base address, image size, kernel size and stride. It then walks the image BRAM row-major in sliding-window order and streams one pixel per cycle to the PE array under a valid/ready handshake. It raises `done` after the last window element has been accepted.

## Interface
Parameters:
- ADDR_WIDTH, 10: image BRAM address width.
- IMG_SIZE_WIDTH, 5: width of the image side length N.
- KERNEL_SIZE_WIDTH, 3: width of the kernel side length K.
- DATA_WIDTH, 8: pixel width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle launch pulse; honoured only in IDLE.
- img_fetch_en  in  1  qualifies start; start with img_fetch_en=0 is ignored.
- img_addr  in  ADDR_WIDTH  image base address.
- img_size  in  IMG_SIZE_WIDTH  N, image is N×N.
- ker_size  in  KERNEL_SIZE_WIDTH  K; K=0 means elementwise, treated as K=1.
- stride2  in  1  1 selects stride 2 (maxpool), 0 selects stride 1.
- bram_img_en  out  1  read enable.
- bram_img_addr  out  ADDR_WIDTH  read address.
- bram_img_dout  in  DATA_WIDTH  read data, valid exactly 1 cycle after bram_img_en.
- win_data  out  DATA_WIDTH  pixel to the PE array.
- win_valid  out  1  win_data valid.
- win_ready  in  1  PE array accepts; a transfer occurs when valid & ready.
- win_last  out  1  marks the final element of the current K×K window.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky until next start; set when K > N.

## Operation
- Inputs are captured on the start edge; later changes are ignored.
- Keff = max(K,1). S = stride2 ? 2 : 1. M = (N−Keff)/S + 1, using floor division.
- Element order: window loop (orow 0..M−1, ocol 0..M−1 inner), then kr 0..Keff−1, then kc 0..Keff−1 innermost.
- Address = img_addr + (orow·S+kr)·N + ocol·S + kc, taken modulo 2^ADDR_WIDTH (wraps silently).
- Addresses are generated incrementally with adders only; no multipliers. Required row-base registers:
  - window base
  - window-row base
  - element-row base
- Total transfers = M·M·Keff·Keff.
- win_last is high with the element at kr=kc=Keff−1.
- Flow control uses credits. credits = FIFO occupancy + reads in flight (maximum 2).
  - A read is issued when credits − pop_this_cycle < 2 and elements remain.
  - The 2-entry FIFO never overflows, and no read is ever dropped.
- FSM states:
  - IDLE: on start & img_fetch_en, go to FETCH, or to DONE if K > N (err=1, zero transfers).
  - FETCH: issue reads. After the last read is issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- N=0 is treated as K > N when Keff ≥ 1, giving err=1.
- start arriving while not in IDLE is ignored.
- Reset in any state: return to IDLE, flush the FIFO, cancel reads in flight (their returning data is discarded).

## Timing
- Reset values: bram_img_en=0, bram_img_addr=0, win_data=0, win_valid=0, win_last=0, busy=0, done=0, err=0.
- Cycle 0: start sampled.
- Cycle 1: state FETCH, busy=1, bram_img_en=1, first address presented.
- Cycle 2: bram_img_dout valid.
- Cycle 3: win_valid=1 (registered FIFO head).
- Throughput is 1 element/cycle while win_ready=1. Start-to-first-valid latency is 3 cycles.
- win_data and win_last hold steady while valid & !ready.
- done is asserted in the cycle after the final transfer. busy falls in the same cycle done is high.
- Error path: done is asserted at cycle 1, with err=1 at cycle 1.

## Structure
- Shared package: fetch FSM state enum (IDLE/FETCH/DRAIN/DONE) and stride encoding constants, alongside the existing opcode/OP_SEL definitions.
- Sub-module `win_fifo`: 2-entry synchronous FIFO carrying {win_last, data}. It exposes count, push, and pop, with a first-word-fall-through registered output.
- Parent contains the FSM, the loop counters (orow, ocol, kr, kc), the address accumulators, and the credit logic.

## Test plan
- N=3, K=2, S=1, img_addr=0x010, win_ready=1: 16 transfers at addresses 10,11,13,14, 11,12,14,15, 13,14,16,17, 14,15,17,18. win_last is high on every 4th transfer. done is asserted 1 cycle after the 16th transfer.
- N=4, K=2, stride2=1, base 0: 16 transfers at addresses 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15.
- ReLU mode, K=0, N=3, base 0x020: 9 transfers at 0x20..0x28, each with win_last=1.
- Back-pressure with win_ready toggling randomly 50%: the data sequence matches the unstalled run, no element is lost or duplicated, and bram_img_en never fires with credits=2 and no pop.
- K=5, N=3: no bram_img_en, err=1, done at cycle 1. A following valid start clears err.
- Wrap and reset:
  - base 0x3FE, N=2, K=1 reads 3FE, 3FF, 000, 001.
  - rstn pulsed mid-FETCH returns all outputs to reset values.
  - A fresh start afterwards runs cleanly.
